lcd_frame_capture: RTL and testbench

//   Downstream of the gameboy core's LCD outputs (pixel_data/pixel_latch/hsync/vsync).

---
 rtl/lcd_frame_capture_if.sv | 29 ++
 rtl/lcd_frame_capture.sv | 163 ++++++++++++++++
 tb/tb_lcd_frame_capture.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_frame_capture_if.sv
// Pixel-stream input, framebuffer write port and status flags of lcd_frame_capture.
// slave is the capture block's view; master is the driving/observing side.
interface lcd_frame_capture_if #(
  parameter int ADDR_W = 13
);
  logic [1:0]        pixel_data;
  logic              pixel_latch;
  logic              hsync;
  logic              vsync;
  logic [ADDR_W-1:0] fb_addr;
  logic [7:0]        fb_data;
  logic              fb_we;
  logic              fb_ready;
  logic              frame_done;
  logic              err_clr;
  logic              line_err;
  logic              frame_err;
  logic              ovf_err;

  modport slave (
    input  pixel_data, pixel_latch, hsync, vsync, fb_ready, err_clr,
    output fb_addr, fb_data, fb_we, frame_done, line_err, frame_err, ovf_err
  );

  modport master (
    output pixel_data, pixel_latch, hsync, vsync, fb_ready, err_clr,
    input  fb_addr, fb_data, fb_we, frame_done, line_err, frame_err, ovf_err
  );
endinterface

// File: rtl/lcd_frame_capture.sv
// Packs the LCD 2-bit pixel stream 4-per-byte into a framebuffer; byte reaches fb_we one cycle after it completes.
// fb_* hold while fb_ready=0; one pending slot absorbs a second byte, a third is dropped and flagged in ovf_err.
module lcd_frame_capture #(
  parameter int H_PIXELS = 160,
  parameter int V_LINES  = 144,
  parameter int ADDR_W   = 13,
  parameter int FB_BASE  = 0
) (
  input  logic i_clock,
  input  logic i_reset_n,
  lcd_frame_capture_if.slave io_lcd
);
  localparam int XW = $clog2(H_PIXELS + 1);
  localparam int YW = $clog2(V_LINES + 1);
  localparam logic [XW-1:0]     LP_XMAX  = XW'(H_PIXELS);
  localparam logic [YW-1:0]     LP_YLAST = YW'(V_LINES - 1);
  localparam logic [YW-1:0]     LP_YMAX  = YW'(V_LINES);
  localparam logic [ADDR_W-1:0] LP_BASE  = ADDR_W'(FB_BASE);
  localparam logic [ADDR_W-1:0] LP_BPL   = ADDR_W'(H_PIXELS / 4);

  typedef enum logic [1:0] {S_WAIT_VSYNC, S_ACTIVE, S_DONE} state_t;

  state_t            r_state;
  logic              r_hs_q, r_vs_q;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [7:0]        r_pack;
  logic              r_out_vld, r_pend_vld;
  logic [ADDR_W-1:0] r_out_addr, r_pend_addr;
  logic [7:0]        r_out_dat, r_pend_dat;
  logic              r_fd_wait, r_frame_done;
  logic              r_line_err, r_frame_err, r_ovf_err;

  logic              w_hs_rise, w_vs_rise, w_active, w_restart;
  logic              w_pix, w_pix_ok, w_pix_drop;
  logic [XW-1:0]     w_x_n;
  logic [XW-3:0]     w_col;
  logic [7:0]        w_pack_n, w_byte_dat;
  logic [ADDR_W-1:0] w_byte_addr;
  logic              w_line_end, w_last_end, w_full, w_flush, w_byte_vld;
  logic              w_acc, w_out_free, w_ovf;
  logic              w_out_vld_n, w_pend_vld_n, w_empty_n, w_line_bad;

  assign w_hs_rise  = io_lcd.hsync & ~r_hs_q;
  assign w_vs_rise  = io_lcd.vsync & ~r_vs_q;
  assign w_active   = (r_state == S_ACTIVE);
  assign w_restart  = w_active & w_vs_rise;

  // A restarting vsync overrides pixels and line ends arriving in the same cycle.
  assign w_pix      = w_active & ~w_vs_rise & io_lcd.pixel_latch;
  assign w_pix_ok   = w_pix & (r_x < LP_XMAX);
  assign w_pix_drop = w_pix & ~w_pix_ok;
  assign w_x_n      = r_x + XW'(w_pix_ok);
  assign w_pack_n   = w_pix_ok ? {r_pack[5:0], io_lcd.pixel_data} : r_pack;

  assign w_line_end = w_active & ~w_vs_rise & w_hs_rise;
  assign w_last_end = w_line_end & (r_y == LP_YLAST);
  assign w_line_bad = w_line_end & (w_x_n != LP_XMAX);
  assign w_full     = w_pix_ok & (w_x_n[1:0] == 2'b00);
  assign w_flush    = w_line_end & (w_x_n[1:0] != 2'b00);
  assign w_byte_vld = w_full | w_flush;
  assign w_col      = w_full ? r_x[XW-1:2] : w_x_n[XW-1:2];
  assign w_byte_addr = LP_BASE + ADDR_W'(r_y) * LP_BPL + ADDR_W'(w_col);

  // Pack register is a plain shift register; a partial group is left-aligned so stale bits fall off.
  always_comb begin
    w_byte_dat = w_pack_n;
    case (w_x_n[1:0])
      2'd1:    w_byte_dat = {w_pack_n[1:0], 6'd0};
      2'd2:    w_byte_dat = {w_pack_n[3:0], 4'd0};
      2'd3:    w_byte_dat = {w_pack_n[5:0], 2'd0};
      default: w_byte_dat = w_pack_n;
    endcase
  end

  assign w_acc        = r_out_vld & io_lcd.fb_ready;
  assign w_out_free   = ~r_out_vld | w_acc;
  assign w_ovf        = w_byte_vld & ~w_out_free & r_pend_vld;
  assign w_out_vld_n  = w_out_free ? (r_pend_vld | w_byte_vld) : 1'b1;
  assign w_pend_vld_n = w_out_free ? (r_pend_vld & w_byte_vld) : (r_pend_vld | w_byte_vld);
  assign w_empty_n    = ~w_out_vld_n & ~w_pend_vld_n;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= S_WAIT_VSYNC;
      r_hs_q       <= 1'b0;
      r_vs_q       <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_pack       <= '0;
      r_out_vld    <= 1'b0;
      r_out_addr   <= '0;
      r_out_dat    <= '0;
      r_pend_vld   <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_dat   <= '0;
      r_fd_wait    <= 1'b0;
      r_frame_done <= 1'b0;
      r_line_err   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_ovf_err    <= 1'b0;
    end else begin
      r_hs_q <= io_lcd.hsync;
      r_vs_q <= io_lcd.vsync;
      r_pack <= w_pack_n;

      case (r_state)
        S_WAIT_VSYNC, S_DONE: begin
          if (w_vs_rise) begin
            r_state <= S_ACTIVE;
            r_x     <= '0;
            r_y     <= '0;
          end
        end
        S_ACTIVE: begin
          if (w_vs_rise) begin
            r_x <= '0;
            r_y <= '0;
          end else if (w_line_end) begin
            r_x <= '0;
            r_y <= (r_y == LP_YMAX) ? r_y : r_y + YW'(1);
            if (w_last_end) r_state <= S_DONE;
          end else begin
            r_x <= w_x_n;
          end
        end
        default: r_state <= S_WAIT_VSYNC;
      endcase

      r_out_vld  <= w_out_vld_n;
      r_pend_vld <= w_pend_vld_n;
      if (w_out_free) begin
        if (r_pend_vld) begin
          r_out_addr <= r_pend_addr;
          r_out_dat  <= r_pend_dat;
        end else if (w_byte_vld) begin
          r_out_addr <= w_byte_addr;
          r_out_dat  <= w_byte_dat;
        end
      end
      if (w_byte_vld && (w_out_free == r_pend_vld)) begin
        r_pend_addr <= w_byte_addr;
        r_pend_dat  <= w_byte_dat;
      end

      // frame_done waits until the last line has ended and nothing is left in the output stage.
      r_fd_wait    <= (w_last_end | r_fd_wait) & ~w_empty_n;
      r_frame_done <= (w_last_end | r_fd_wait) & w_empty_n;

      r_line_err  <= (r_line_err & ~io_lcd.err_clr) | w_pix_drop | w_line_bad;
      r_frame_err <= (r_frame_err & ~io_lcd.err_clr) | w_restart;
      r_ovf_err   <= (r_ovf_err & ~io_lcd.err_clr) | w_ovf;
    end
  end

  assign io_lcd.fb_we      = r_out_vld;
  assign io_lcd.fb_addr    = r_out_addr;
  assign io_lcd.fb_data    = r_out_dat;
  assign io_lcd.frame_done = r_frame_done;
  assign io_lcd.line_err   = r_line_err;
  assign io_lcd.frame_err  = r_frame_err;
  assign io_lcd.ovf_err    = r_ovf_err;
endmodule

// File: tb/tb_lcd_frame_capture.sv
// Directed + randomized bench for lcd_frame_capture against a line/byte-level framebuffer model.
module tb_lcd_frame_capture;
  localparam int H  = 160;
  localparam int V  = 144;
  localparam int AW = 13;
  localparam int BASE = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lcd_frame_capture_if #(.ADDR_W(AW)) lcd_if();

  lcd_frame_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW), .FB_BASE(BASE)) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .io_lcd   (lcd_if.slave)
  );

  int checks = 0;
  int errors = 0;
  int fd_count = 0;
  int m_y = 0;
  int low_run = 0;
  bit m_active = 0;
  bit rand_rdy = 0;
  bit exp_le = 0, exp_fe = 0, exp_oe = 0;
  logic [AW+7:0] exp_q[$];
  logic [1:0] pat[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every presented write must match the head of the expected stream, stalled or not.
  task automatic monitor();
    logic [AW+7:0] head;
    if (!rst_n) return;
    if (lcd_if.frame_done) fd_count++;
    if (lcd_if.fb_we) begin
      chk("write_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        chk("fb_addr", 32'(lcd_if.fb_addr), 32'(head[AW+7:8]));
        chk("fb_data", 32'(lcd_if.fb_data), 32'(head[7:0]));
        if (lcd_if.fb_ready) void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (rand_rdy) begin
      if (low_run >= 2) lcd_if.fb_ready = 1'b1;
      else lcd_if.fb_ready = ($urandom_range(0, 2) != 0);
      low_run = lcd_if.fb_ready ? 0 : low_run + 1;
    end
  endtask

  task automatic fill_pat(input int n, input int mode);
    pat.delete();
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       pat.push_back(2'(i % 4));
        1:       pat.push_back(2'd3);
        default: pat.push_back(2'($urandom_range(0, 3)));
      endcase
    end
  endtask

  // Reference: a line of n pixels yields ceil(min(n,H)/4) bytes at row m_y, zero-filled tail.
  task automatic model_line(input int n);
    int eff;
    logic [7:0] b;
    logic [AW-1:0] a;
    eff = (n < H) ? n : H;
    for (int g = 0; g < (eff + 3) / 4; g++) begin
      b = 8'h00;
      for (int k = 0; k < 4; k++)
        if (4 * g + k < eff) b[7 - 2 * k -: 2] = pat[4 * g + k];
      a = AW'(BASE + m_y * (H / 4) + g);
      exp_q.push_back({a, b});
    end
    if (n != H) exp_le = 1;
    m_y++;
    if (m_y == V) m_active = 0;
  endtask

  task automatic send_pix(input int n, input bit coinc, input bit gaps);
    for (int i = 0; i < n; i++) begin
      lcd_if.pixel_data  = pat[i];
      lcd_if.pixel_latch = 1'b1;
      if (coinc && i == n - 1) lcd_if.hsync = 1'b1;
      tick();
      lcd_if.pixel_latch = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) tick();
    end
    lcd_if.hsync = 1'b0;
  endtask

  task automatic end_line();
    lcd_if.hsync = 1'b1;
    tick();
    lcd_if.hsync = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_line(input int n, input bit coinc, input bit gaps);
    model_line(n);
    send_pix(n, coinc, gaps);
    if (coinc) begin
      tick();
      tick();
    end else begin
      end_line();
    end
    tick();
  endtask

  task automatic vsync_pulse();
    if (m_active) exp_fe = 1;
    m_active = 1;
    m_y = 0;
    lcd_if.vsync = 1'b1;
    tick();
    lcd_if.vsync = 1'b0;
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
    chk("drain_remaining", 32'(exp_q.size()), 0);
    tick();
    tick();
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_line_err"},  32'(lcd_if.line_err),  32'(exp_le));
    chk({tag, "_frame_err"}, 32'(lcd_if.frame_err), 32'(exp_fe));
    chk({tag, "_ovf_err"},   32'(lcd_if.ovf_err),   32'(exp_oe));
  endtask

  task automatic clear_errs();
    lcd_if.err_clr = 1'b1;
    tick();
    lcd_if.err_clr = 1'b0;
    exp_le = 0;
    exp_fe = 0;
    exp_oe = 0;
    check_flags("after_clr");
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_fb_we"},      32'(lcd_if.fb_we), 0);
    chk({tag, "_fb_addr"},    32'(lcd_if.fb_addr), 0);
    chk({tag, "_fb_data"},    32'(lcd_if.fb_data), 0);
    chk({tag, "_frame_done"}, 32'(lcd_if.frame_done), 0);
    chk({tag, "_line_err"},   32'(lcd_if.line_err), 0);
    chk({tag, "_frame_err"},  32'(lcd_if.frame_err), 0);
    chk({tag, "_ovf_err"},    32'(lcd_if.ovf_err), 0);
  endtask

  initial begin
    logic [7:0] b0, b1;
    rst_n = 1'b0;
    lcd_if.pixel_data = 2'd0;
    lcd_if.pixel_latch = 1'b0;
    lcd_if.hsync = 1'b0;
    lcd_if.vsync = 1'b0;
    lcd_if.fb_ready = 1'b0;
    lcd_if.err_clr = 1'b0;
    #1;
    check_outputs_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Full frame, shade = x%4, no backpressure.
    lcd_if.fb_ready = 1'b1;
    vsync_pulse();
    for (int y = 0; y < V; y++) begin
      fill_pat(H, 0);
      send_line(H, 0, 0);
    end
    drain();
    chk("t1_frame_done_count", 32'(fd_count), 1);
    check_flags("t1");

    // Stall with one byte held and one pending.
    vsync_pulse();
    lcd_if.fb_ready = 1'b0;
    pat.delete();
    pat.push_back(2'd3); pat.push_back(2'd2); pat.push_back(2'd1); pat.push_back(2'd0);
    pat.push_back(2'd0); pat.push_back(2'd1); pat.push_back(2'd2); pat.push_back(2'd3);
    model_line(8);
    send_pix(8, 0, 0);
    tick();
    tick();
    chk("t2_we_held", 32'(lcd_if.fb_we), 1);
    chk("t2_addr_held", 32'(lcd_if.fb_addr), 0);
    chk("t2_data_held", 32'(lcd_if.fb_data), 32'h0E4);
    lcd_if.fb_ready = 1'b1;
    drain();
    end_line();
    check_flags("t2");

    // Short line: flush with zero fill, next line at row 1.
    vsync_pulse();
    check_flags("t3_vsync");
    clear_errs();
    fill_pat(6, 1);
    model_line(6);
    for (int i = 0; i < 6; i++) begin
      lcd_if.pixel_data = pat[i];
      lcd_if.pixel_latch = 1'b1;
      tick();
      if (i == 3) begin
        chk("t3_latency_we", 32'(lcd_if.fb_we), 1);
        chk("t3_latency_addr", 32'(lcd_if.fb_addr), 0);
      end
    end
    lcd_if.pixel_latch = 1'b0;
    end_line();
    check_flags("t3_short");
    rand_rdy = 1;
    fill_pat(H, 2);
    send_line(H, 0, 1);
    drain();
    rand_rdy = 0;
    lcd_if.fb_ready = 1'b1;
    clear_errs();

    // Three bytes under backpressure: third is dropped.
    vsync_pulse();
    lcd_if.fb_ready = 1'b0;
    fill_pat(12, 2);
    b0 = {pat[0], pat[1], pat[2], pat[3]};
    b1 = {pat[4], pat[5], pat[6], pat[7]};
    exp_q.push_back({AW'(BASE), b0});
    exp_q.push_back({AW'(BASE + 1), b1});
    send_pix(12, 0, 0);
    exp_oe = 1;
    check_flags("t4_ovf");
    lcd_if.fb_ready = 1'b1;
    drain();
    lcd_if.err_clr = 1'b1;
    tick();
    lcd_if.err_clr = 1'b0;
    chk("t4_ovf_cleared", 32'(lcd_if.ovf_err), 0);
    exp_le = 0;
    exp_fe = 0;
    exp_oe = 0;
    tick();
    check_flags("t4_clr");

    // Random lines with random backpressure, then an early vsync.
    vsync_pulse();
    clear_errs();
    rand_rdy = 1;
    for (int l = 0; l < 10; l++) begin
      int n;
      n = ($urandom_range(0, 1) != 0) ? H : int'($urandom_range(1, 170));
      fill_pat(n, 2);
      send_line(n, 1'($urandom_range(0, 1)), 1);
    end
    drain();
    check_flags("t5_lines");
    vsync_pulse();
    check_flags("t5_early_vsync");
    fill_pat(4, 2);
    send_line(4, 0, 0);
    drain();
    check_flags("t5_restart");

    // Reset mid-line, then sync-less traffic must be ignored.
    rand_rdy = 0;
    lcd_if.fb_ready = 1'b1;
    fill_pat(2, 2);
    send_pix(2, 0, 0);
    rst_n = 1'b0;
    exp_q.delete();
    exp_le = 0;
    exp_fe = 0;
    exp_oe = 0;
    m_active = 0;
    m_y = 0;
    #2;
    check_outputs_zero("mid_reset");
    tick();
    rst_n = 1'b1;
    tick();
    fill_pat(8, 2);
    send_pix(8, 0, 0);
    end_line();
    chk("wait_vsync_no_write", 32'(lcd_if.fb_we), 0);
    check_flags("wait_vsync");

    // pixel_latch coincident with hsync on the last pixel of a line.
    vsync_pulse();
    rand_rdy = 1;
    fill_pat(H, 2);
    send_line(H, 1, 0);
    check_flags("t6_first");
    fill_pat(H, 2);
    send_line(H, 1, 1);
    drain();
    check_flags("t6_second");
    chk("final_frame_done_count", 32'(fd_count), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
